// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Multi-port integer register file with a per-register busy scoreboard.
//   Register 0 is hardwired to zero. Reads are combinational and pick up
//   same-cycle writes through a bypass. Writes, releases, allocates and
//   flushes take effect at the rising edge.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset (clears regs, busy, count)
//   rd_addr    : NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    : NUM_RD packed read data (combinational)
//   rd_busy    : per read port, 1 = addressed register has a pending writer
//   wr_en      : NUM_WR write enables (higher index has priority)
//   wr_addr    : NUM_WR packed write addresses
//   wr_data    : NUM_WR packed write data
//   alloc_en   : mark alloc_addr busy
//   alloc_addr : register being allocated
//   flush      : clear every busy bit (overrides alloc)
//   busy_count : registered number of busy registers
module regfile_scoreboard #(
  parameter int NUM_REG = 32,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int NUM_RD  = 3,
  parameter int NUM_WR  = 2,
  parameter int CNT_W   = $clog2(NUM_REG + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     flush,
  output logic [CNT_W-1:0]         busy_count
);

  // Flattened view of all register contents; slice 0 is the zero register.
  logic [NUM_REG*DATA_W-1:0] regs_flat;
  logic [NUM_REG-1:0]        busy_q;
  logic [NUM_REG-1:0]        busy_d;
  logic [CNT_W-1:0]          busy_count_q;
  logic [CNT_W-1:0]          busy_count_d;

  assign regs_flat[DATA_W-1:0] = '0;
  assign busy_d[0]             = 1'b0;

  // Per-register storage and scoreboard next-state. Addresses >= NUM_REG
  // never match any generated register, so such writes/allocates vanish.
  for (genvar gi = 1; gi < NUM_REG; gi++) begin : g_reg
    logic [DATA_W-1:0] reg_q;
    logic [DATA_W-1:0] reg_d;
    logic              release_hit;
    logic              alloc_hit;
    logic              busy_bit_d;

    always_comb begin
      reg_d       = reg_q;
      release_hit = 1'b0;
      // Ascending scan: the highest-indexed matching port lands last and wins.
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(gi))) begin
          reg_d       = wr_data[j*DATA_W +: DATA_W];
          release_hit = 1'b1;
        end
      end
    end

    assign alloc_hit = alloc_en && (alloc_addr == ADDR_W'(gi));

    // Priority: flush > allocate (newer writer outstanding) > release > hold.
    always_comb begin
      busy_bit_d = busy_q[gi];
      if (flush) begin
        busy_bit_d = 1'b0;
      end else if (alloc_hit) begin
        busy_bit_d = 1'b1;
      end else if (release_hit) begin
        busy_bit_d = 1'b0;
      end
    end

    assign busy_d[gi] = busy_bit_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign regs_flat[gi*DATA_W +: DATA_W] = reg_q;
  end

  // Popcount of the next busy vector so the count tracks busy with no lag.
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      busy_count_d = busy_count_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  // Read ports: zero/out-of-range -> 0; else bypass beats array contents.
  for (genvar gk = 0; gk < NUM_RD; gk++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign addr = rd_addr[gk*ADDR_W +: ADDR_W];

    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if ((addr != '0) && (32'(addr) < NUM_REG)) begin
        for (int r = 0; r < NUM_REG; r++) begin
          if (addr == ADDR_W'(r)) begin
            data = regs_flat[r*DATA_W +: DATA_W];
            bsy  = busy_q[r];
          end
        end
        // A write in flight this cycle supplies the data and retires the hazard.
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == addr)) begin
            data = wr_data[j*DATA_W +: DATA_W];
            bsy  = 1'b0;
          end
        end
      end
    end

    assign rd_data[gk*DATA_W +: DATA_W] = data;
    assign rd_busy[gk]                  = bsy;
  end

endmodule
